im_cache: RTL
=============

// Module: im_cache
// PURPOSE
//   Instruction-memory responder behind the fetch stage: direct-mapped, read-only instruction cache.
//   Fetch side: enable/addr in; registered pc_out/data/stall back, one cycle after the request.
//   On a miss it refills the full line from a slower backing memory over a req/ack word interface.
//   While refilling it holds stall high.
// PARAMETERS
//   LINES       16  cache lines (power of 2, >=2)
//   LINE_WORDS  4   32-bit words per line (power of 2, >=2)
// PORTS
//   clk        in   1   clock, all state on posedge
//   rst        in   1   asynchronous reset, ACTIVE-LOW (asserted while 0)
//   enable     in   1   fetch request; addr sampled on posedge when 1 and stall=0
//   addr       in   32  fetch byte address; bits [1:0] ignored for lookup
//   pc_out     out  32  address of the request the current data belongs to
//   data       out  32  instruction word for pc_out; valid when stall=0
//   stall      out  1   1 = miss being serviced; data/pc_out not valid
//   inv        in   1   invalidate all lines (one-cycle pulse)
//   mem_req    out  1   backing read request
//   mem_addr   out  32  backing word address (byte addr, [1:0]=0)
//   mem_ack    in   1   backing read complete this cycle; mem_rdata valid
//   mem_rdata  in   32  backing read data
// BEHAVIOUR
// - Address split: offset = addr[log2(LINE_WORDS)+1:2], index = next log2(LINES) bits, tag = remainder.
// - Storage: data array, tag array, per-line valid bit.
// - Reset (rst=0, async):
//   - all valid bits cleared; FSM -> IDLE
//   - pc_out=0, data=0, stall=0, mem_req=0, mem_addr=0
// - FSM IDLE:
//   - enable=1 at posedge, hit (valid & tag match): next cycle pc_out=addr, data=word, stall=0.
//   - enable=1 at posedge, miss: latch addr; go to REFILL with word counter=0; stall=1 from the next cycle.
//   - enable=0: pc_out/data/stall hold previous values, so the last fetched instruction persists.
// - FSM REFILL:
//   - mem_req=1; mem_addr = {tag, index, counter, 2'b00}, held stable until mem_ack.
//   - On each mem_ack: write mem_rdata into the line at counter, then counter+1.
//   - On the ack of word LINE_WORDS-1: write the tag, set valid, go to RESP.
//     mem_req drops in the following cycle. The final word is written and the next request is not issued.
//   - enable is ignored throughout (fetch holds it low while stall=1).
// - FSM RESP (entered on the edge of the last ack):
//   - Outputs load at that edge: pc_out = latched addr, data = requested word, stall=0.
//     data comes from the captured mem_rdata if offset = LINE_WORDS-1.
//   - Go to IDLE.
//   - Latency with mem_ack=1 every cycle: request sampled at cycle 0; stall=1 cycles 1..LINE_WORDS; data valid at cycle LINE_WORDS+1.
// - inv:
//   - In IDLE: clears all valid bits at the edge.
//   - Same edge as enable: the lookup uses the pre-invalidate state.
//   - During REFILL: clears all other lines. The line under refill still completes and becomes valid.
// - Counter wraps are impossible: it is cleared on REFILL entry.
// - Addresses differing only in [1:0] hit the same word. pc_out reports addr exactly as sampled.
// - Conflict miss (same index, other tag) overwrites the line. There is no write path.
// TESTING
// 1. Reset:
//    - Hold rst=0 mid-stream -> pc_out=0, data=0, stall=0, mem_req=0.
//    - After release, a fetch of 0x100 misses.
// 2. Cold miss, mem_ack=1 always:
//    - enable, addr=0x0000_0108 at cycle 0 -> stall=1 cycles 1-4.
//    - mem_addr = 0x100, 0x104, 0x108, 0x10C.
//    - Cycle 5: stall=0, pc_out=0x108, data = mem[0x108].
// 3. Hit after fill:
//    - addr=0x10C -> next cycle stall=0, pc_out=0x10C, data=mem[0x10C], mem_req never asserts.
// 4. Slow memory + conflict:
//    - mem_ack two cycles after each req; fetch 0x0000_1100 (same index as 0x100) -> mem_addr held stable 2 cycles per word.
//    - stall=1 for 8 cycles. A later fetch of 0x100 misses again.
// 5. Hold and invalidate:
//    - enable=0 for 5 cycles after a hit -> pc_out/data unchanged.
//    - Pulse inv, then fetch 0x100 -> miss and refill.
// 6. Reset mid-refill:
//    - rst=0 after 2 acked words -> mem_req=0 immediately.
//    - After release, fetch 0x100 refills from 0x100 (word 0) and asserts stall again.

Source files
------------

// File: rtl/im_cache.sv
// ============================================================================
//  Module   : im_cache
//  Purpose  : Direct-mapped, read-only instruction cache sitting behind the
//             fetch stage. Hits answer one cycle after the request; misses
//             refill the whole line from a slower backing memory over a
//             word-wide req/ack interface while holding stall high.
//  Ports    : clk, rst (async, active-low)
//             enable/addr        - fetch request (sampled when stall=0)
//             pc_out/data/stall  - registered fetch response
//             inv                - invalidate all lines (pulse)
//             mem_req/mem_addr   - backing read request / word address
//             mem_ack/mem_rdata  - backing read completion / data
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module im_cache #(
    parameter int LINES      = 16,
    parameter int LINE_WORDS = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic [31:0] addr,
    output logic [31:0] pc_out,
    output logic [31:0] data,
    output logic        stall,
    input  logic        inv,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata
);

    localparam int c_OFF_W  = $clog2(LINE_WORDS);
    localparam int c_IDX_W  = $clog2(LINES);
    localparam int c_TAG_W  = 30 - c_OFF_W - c_IDX_W;
    localparam int c_LO_IDX = 2 + c_OFF_W;
    localparam int c_LO_TAG = c_LO_IDX + c_IDX_W;
    localparam logic [c_OFF_W-1:0] c_LAST = c_OFF_W'(LINE_WORDS - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_REFILL = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    // Storage: data and tags carry no reset, only the valid bits do.
    logic [31:0]         r_mem [LINES*LINE_WORDS];
    logic [c_TAG_W-1:0]  r_tag [LINES];
    logic [LINES-1:0]    r_valid;
    logic [LINES-1:0]    w_valid_nxt;

    logic [31:0]         r_miss_addr;
    logic [c_OFF_W-1:0]  r_cnt;
    logic [31:0]         r_pc;
    logic [31:0]         r_data;
    logic                r_stall;

    // Fetch address decode
    logic [c_OFF_W-1:0]  w_off;
    logic [c_IDX_W-1:0]  w_idx;
    logic [c_TAG_W-1:0]  w_tag;
    logic                w_hit;

    // Latched miss address decode
    logic [c_OFF_W-1:0]  w_miss_off;
    logic [c_IDX_W-1:0]  w_miss_idx;
    logic [c_TAG_W-1:0]  w_miss_tag;
    logic                w_fill_word;
    logic                w_last;

    logic                w_unused_addr;

    assign w_off = addr[2 +: c_OFF_W];
    assign w_idx = addr[c_LO_IDX +: c_IDX_W];
    assign w_tag = addr[31:c_LO_TAG];
    assign w_hit = r_valid[w_idx] && (r_tag[w_idx] == w_tag);

    assign w_miss_off = r_miss_addr[2 +: c_OFF_W];
    assign w_miss_idx = r_miss_addr[c_LO_IDX +: c_IDX_W];
    assign w_miss_tag = r_miss_addr[31:c_LO_TAG];

    assign w_fill_word = (r_state == ST_REFILL) && mem_ack;
    assign w_last      = w_fill_word && (r_cnt == c_LAST);

    // Byte-lane bits never take part in the lookup.
    assign w_unused_addr = &{1'b0, addr[1:0]};

    // ------------------------------------------------------------------
    // Next-state and memory-side outputs
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        mem_req     = 1'b0;
        mem_addr    = 32'h0;
        case (r_state)
            // RESP already reports stall=0, so a new fetch is served there
            // exactly as in IDLE.
            ST_IDLE, ST_RESP: begin
                w_state_nxt = ST_IDLE;
                if (enable && !w_hit) begin
                    w_state_nxt = ST_REFILL;
                end
            end
            ST_REFILL: begin
                mem_req  = 1'b1;
                mem_addr = {r_miss_addr[31:c_LO_IDX], r_cnt, 2'b00};
                if (w_last) begin
                    w_state_nxt = ST_RESP;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Invalidate wipes every line; a refill finishing on the same edge still
    // marks its own line valid.
    always_comb begin
        w_valid_nxt = inv ? '0 : r_valid;
        if (w_last) begin
            w_valid_nxt[w_miss_idx] = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Control state and fetch-side response registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= ST_IDLE;
            r_valid     <= '0;
            r_miss_addr <= 32'h0;
            r_cnt       <= '0;
            r_pc        <= 32'h0;
            r_data      <= 32'h0;
            r_stall     <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_valid <= w_valid_nxt;
            case (r_state)
                ST_IDLE, ST_RESP: begin
                    if (enable) begin
                        if (w_hit) begin
                            r_pc    <= addr;
                            r_data  <= r_mem[{w_idx, w_off}];
                            r_stall <= 1'b0;
                        end else begin
                            r_miss_addr <= addr;
                            r_cnt       <= '0;
                            r_stall     <= 1'b1;
                        end
                    end
                end
                ST_REFILL: begin
                    if (mem_ack) begin
                        r_cnt <= r_cnt + 1'b1;
                        if (r_cnt == c_LAST) begin
                            r_pc    <= r_miss_addr;
                            // The final word is still on mem_rdata this edge;
                            // earlier words already sit in the array.
                            r_data  <= (w_miss_off == c_LAST) ? mem_rdata
                                     : r_mem[{w_miss_idx, w_miss_off}];
                            r_stall <= 1'b0;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Line fill: data word per ack, tag on the last word
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (w_fill_word) begin
            r_mem[{w_miss_idx, r_cnt}] <= mem_rdata;
            if (r_cnt == c_LAST) begin
                r_tag[w_miss_idx] <= w_miss_tag;
            end
        end
    end

    assign pc_out = r_pc;
    assign data   = r_data;
    assign stall  = r_stall;

endmodule

`default_nettype wire
